fan_speed_sched: RTL

//  Closed-loop speed scheduler for the refrigeration fan motor PWM block. Maps a

---
 rtl/fan_pkg.sv | 15 +
 rtl/fan_speed_sched_dwell_timer.sv | 28 ++
 rtl/fan_speed_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fan_pkg.sv
// Shared level constants and FSM encoding for the fan speed scheduler.
package fan_pkg;

    localparam logic [1:0] LVL_MIN = 2'b00;
    localparam logic [1:0] LVL_LO  = 2'b01;
    localparam logic [1:0] LVL_HI  = 2'b10;
    localparam logic [1:0] LVL_MAX = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_STABLE = 2'b01,
        ST_DWELL  = 2'b10
    } fan_state_t;

endpackage

// File: rtl/fan_speed_sched_dwell_timer.sv
// Dwell down-counter: load wins over tick, counting stops at zero.
module dwell_timer #(
    parameter int DW = 26
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          tick,
    output logic          zero
);

    logic [DW-1:0] count;

    // Reload or count down toward the terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fan_speed_sched.sv
// Temperature-driven fan speed scheduler with hysteresis, single-level
// stepping and a minimum dwell per level.
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  OFF    | disabled, giro held at 00, dwell cleared
//  STABLE | dwell expired, giro steps toward target when they differ
//  DWELL  | holding the current level until the dwell counter hits 0
module fan_speed_sched
    import fan_pkg::*;
#(
    parameter logic [7:0] T1           = 8'd20,
    parameter logic [7:0] T2           = 8'd25,
    parameter logic [7:0] T3           = 8'd30,
    parameter logic [7:0] HYST         = 8'd2,
    parameter int         DWELL_CYCLES = 50_000_000,
    parameter int         DW           = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    input  logic       manual,
    input  logic [1:0] man_level,
    output logic [1:0] giro,
    output logic       busy,
    output logic       level_chg
);

    // Lower (falling-edge) thresholds; HYST <= T1 keeps these from wrapping.
    localparam logic [7:0] T1_DN = T1 - HYST;
    localparam logic [7:0] T2_DN = T2 - HYST;
    localparam logic [7:0] T3_DN = T3 - HYST;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    fan_state_t    state, state_nxt;
    logic [1:0]    target;
    logic [1:0]    auto_target;
    logic [1:0]    giro_nxt;
    logic          chg_nxt;
    logic          tmr_load;
    logic [DW-1:0] tmr_val;
    logic          tmr_tick;
    logic          tmr_zero;
    logic          h1, h2, h3;

    // Hysteretic level decode: a level already reached stays until temp
    // falls HYST below its threshold.
    always_comb begin
        h1 = (temp >= T1) || ((target >= LVL_LO)  && (temp >= T1_DN));
        h2 = (temp >= T2) || ((target >= LVL_HI)  && (temp >= T2_DN));
        h3 = (temp >= T3) || ((target >= LVL_MAX) && (temp >= T3_DN));
        auto_target = {1'b0, h1} + {1'b0, h2} + {1'b0, h3};
    end

    // Target register: manual level every cycle, else auto level on a valid sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target <= LVL_MIN;
        end else if (manual) begin
            target <= man_level;
        end else if (temp_valid) begin
            target <= auto_target;
        end
    end

    // Next-state, next-level and timer control; enable=0 overrides everything.
    always_comb begin
        state_nxt = state;
        giro_nxt  = giro;
        chg_nxt   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = DWELL_LOAD;
        tmr_tick  = 1'b0;
        if (!enable) begin
            state_nxt = ST_OFF;
            giro_nxt  = LVL_MIN;
            chg_nxt   = (giro != LVL_MIN);
            tmr_load  = 1'b1;
            tmr_val   = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nxt = ST_DWELL;
                    tmr_load  = 1'b1;
                end
                ST_STABLE: begin
                    if (target != giro) begin
                        giro_nxt  = (target > giro) ? giro + 2'd1 : giro - 2'd1;
                        chg_nxt   = 1'b1;
                        tmr_load  = 1'b1;
                        state_nxt = ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    tmr_tick = 1'b1;
                    if (tmr_zero) begin
                        state_nxt = ST_STABLE;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    giro_nxt  = LVL_MIN;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_OFF;
            giro      <= LVL_MIN;
            level_chg <= 1'b0;
        end else begin
            state     <= state_nxt;
            giro      <= giro_nxt;
            level_chg <= chg_nxt;
        end
    end

    assign busy = (state == ST_DWELL) || ((state == ST_STABLE) && (target != giro));

    dwell_timer #(
        .DW(DW)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .zero     (tmr_zero)
    );

endmodule
